// File: rtl/peripheral_control.sv
// Memory-mapped peripheral block: reloadable timer with interrupt, systick,
// LED/7-segment output registers and a synchronized switch input.
module peripheral_control #(
  parameter logic [31:0] BASE = 32'h4000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cre_i,
  input  logic        cwe_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        pc31_i,
  output logic        intreq_o,
  input  logic [7:0]  switch_i,
  output logic [7:0]  led_o,
  output logic [11:0] digi_o
);

  typedef enum logic [2:0] {
    REG_TH      = 3'd0,
    REG_TL      = 3'd1,
    REG_TCON    = 3'd2,
    REG_LED     = 3'd3,
    REG_SWITCH  = 3'd4,
    REG_DIGI    = 3'd5,
    REG_SYSTICK = 3'd6,
    REG_NONE    = 3'd7
  } regSel_e;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] systick_q, systick_d;
  logic [7:0]  swSync1_q, swSync2_q;

  logic [31:0] wordAddr;
  logic [31:0] offset;
  regSel_e     sel;
  logic        overflow;

  // Byte offset within the block; anything at or beyond +0x1C is unmapped.
  assign wordAddr = addr_i & 32'hFFFF_FFFC;
  assign offset   = wordAddr - BASE;
  assign sel      = (offset < 32'h0000_001C) ? regSel_e'(offset[4:2]) : REG_NONE;
  assign overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[0]) begin
      tl_d = overflow ? th_q : tl_q + 32'd1;
    end

    if (cwe_i) begin
      case (sel)
        REG_TH:   th_d   = wdata_i;
        REG_TL:   tl_d   = wdata_i;
        REG_TCON: tcon_d = wdata_i[2:0];
        REG_LED:  led_d  = wdata_i[7:0];
        REG_DIGI: digi_d = wdata_i[11:0];
        default:  ;
      endcase
    end

    // A pending interrupt survives a simultaneous software write to TCON.
    if (overflow && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
      swSync1_q <= '0;
      swSync2_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
      swSync1_q <= switch_i;
      swSync2_q <= swSync1_q;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (cre_i) begin
      case (sel)
        REG_TH:      rdata_o = th_q;
        REG_TL:      rdata_o = tl_q;
        REG_TCON:    rdata_o = {29'd0, tcon_q};
        REG_LED:     rdata_o = {24'd0, led_q};
        REG_SWITCH:  rdata_o = {24'd0, swSync2_q};
        REG_DIGI:    rdata_o = {20'd0, digi_q};
        REG_SYSTICK: rdata_o = systick_q;
        default:     rdata_o = '0;
      endcase
    end
  end

  assign intreq_o = tcon_q[1] & tcon_q[2] & ~pc31_i;
  assign led_o    = led_q;
  assign digi_o   = digi_q;

endmodule
